elevator_call_dispatcher: RTL and testbench
===========================================

// Module: elevator_call_dispatcher
// PURPOSE
//  Initiator side of the elevator request interface. Latches hall/cab call buttons into a
//  pending bitmap and drives request_floor to the elevator core one target at a time.
//  Uses a SCAN (sweep) policy, watches current_floor/moving for arrival, and holds a
//  door-dwell interval before dispatching the next call.
//  Sits between the button panel and the elevator core.
// PARAMETERS
//  NUM_FLOORS    10   floors 0..NUM_FLOORS-1; legal range 2..16
//  DWELL_CYCLES  8    clk cycles door_open stays high after an arrival; must be >= 1
// PORTS
//  clk            in   1           system clock, rising edge
//  rst_n          in   1           asynchronous, active-low reset
//  call_btn       in   NUM_FLOORS  call request, one bit per floor; level or pulse, >=1 cycle
//  current_floor  in   4           floor reported by elevator core
//  moving         in   1           elevator core is in motion
//  direction      in   1           elevator core direction, 1=up 0=down (informational)
//  request_floor  out  4           target floor presented to elevator core; held stable
//  pending        out  NUM_FLOORS  registered call lamps, bit f = call at floor f outstanding
//  door_open      out  1           high for DWELL_CYCLES after each served call
//  served         out  1           one-cycle pulse when a call is cleared
//  sweep_up       out  1           current SCAN sweep direction, 1=up
// BEHAVIOUR
//  Clocking and reset
//  - One clock, clk. rst_n is asynchronous and active-low.
//  - Reset values: request_floor=0, pending=0, door_open=0, served=0, sweep_up=1, state=IDLE.
//  - Reset mid-trip drops all pending calls. request_floor returns to 0 in the same cycle.
//  Call latching
//  - pending <= (pending | call_btn) & ~clear_mask, every cycle.
//  - A call at the floor being cleared in that same cycle is absorbed (not re-latched).
//  FSM states: IDLE, SELECT, TRAVEL, DWELL
//  - IDLE
//    - request_floor = current_floor, so the core does not move.
//    - Go to SELECT the cycle after pending becomes nonzero.
//  - SELECT (1 cycle)
//    - Choose the nearest pending floor in the sweep_up direction.
//      The search is strict: it excludes current_floor.
//    - If none, flip sweep_up and choose the nearest floor in the new direction.
//    - A pending bit at current_floor wins over both: target = current_floor.
//    - Register the target into request_floor and go to TRAVEL.
//    - If pending is empty, go to IDLE.
//  - TRAVEL
//    - Hold request_floor.
//    - Arrival = (current_floor == request_floor) && !moving, sampled while in TRAVEL.
//    - On arrival: clear pending[request_floor], pulse served, load the dwell counter,
//      set door_open, go to DWELL.
//    - A target at current_floor arrives on the first TRAVEL cycle.
//    - New calls do not retarget an in-progress trip.
//  - DWELL
//    - Count DWELL_CYCLES; door_open=1 throughout.
//    - A call at current_floor during DWELL is absorbed and restarts the count.
//    - At terminal count: door_open=0, go to SELECT, or IDLE if pending is empty.
//  Arithmetic
//  - Floor compare is 4-bit unsigned. Priority search is a fixed loop over NUM_FLOORS.
//  - Sweep boundaries: at floor NUM_FLOORS-1 no higher floor exists, so the sweep reverses
//    down. At floor 0 it reverses up.
//  - current_floor >= NUM_FLOORS never matches a pending bit; the dispatcher keeps waiting.
//  Latency
//  - Press to request_floor change: 2 cycles from IDLE (latch, then SELECT).
// STRUCTURE
//  - Shared package elevator_pkg holds:
//    - FLOOR_W=4
//    - localparams MAX_FLOORS=16 and DIR_UP=1'b1 / DIR_DOWN=1'b0
//    - the state encoding
//  - elevator_pkg is shared with the elevator core.
//  - One sub-module: scan_select (combinational).
//    - Inputs: pending, current_floor, sweep_up.
//    - Outputs: found, target, new_sweep_up.
//  - FSM, dwell counter and pending register stay in the top.
// TESTING (bench drives current_floor/moving via a simple 1-floor-per-4-cycle model)
//  1. Reset, call_btn[5] pulse -> request_floor=5 two cycles later; pending[5]=1.
//     At floor 5 with moving=0: served pulse, door_open 8 cycles, pending=0, IDLE.
//  2. At floor 0, calls 7 and 3 together -> serve 3 then 7, all on the up sweep.
//  3. At floor 4, sweep_up, calls 2 and 8 -> 8 first; sweep then flips and serves 2.
//  4. Call at current floor 2 while IDLE -> served within 3 cycles; elevator never moves.
//     Repeat press during DWELL -> dwell restarts; no second served pulse.
//  5. Call 9 during TRAVEL to 6 -> request_floor stays 6 until arrival; 9 served next.
//  6. Assert rst_n low mid-TRAVEL with pending=0x0A4.
//     -> outputs at reset values immediately; no served pulse after release.

Source files
------------

// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : elevator_pkg
//  Description : Shared floor width, floor limits, direction codes and the
//                dispatcher state encoding, common to dispatcher and core.
//  Revision    : 1.0 - initial release
// ============================================================================
package elevator_pkg;

    localparam int FLOOR_W    = 4;
    localparam int MAX_FLOORS = 16;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_TRAVEL = 2'd2,
        ST_DWELL  = 2'd3
    } state_t;

endpackage : elevator_pkg
`default_nettype wire

// File: rtl/scan_select.sv
`default_nettype none
// ============================================================================
//  Module      : scan_select
//  Description : Combinational SCAN target picker. A call at the current
//                floor wins; otherwise the nearest call strictly ahead in the
//                sweep direction; otherwise the sweep flips and the nearest
//                call in the new direction is taken.
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_select
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = 10
)(
    input  logic [NUM_FLOORS-1:0] i_pending,
    input  logic [FLOOR_W-1:0]    i_current_floor,
    input  logic                  i_sweep_up,
    output logic                  o_found,
    output logic [FLOOR_W-1:0]    o_target,
    output logic                  o_new_sweep_up
);

    logic               w_here;
    logic               w_up_found;
    logic               w_dn_found;
    logic [FLOOR_W-1:0] w_up_floor;
    logic [FLOOR_W-1:0] w_dn_floor;

    // Pending call at the floor the car is already standing on
    always_comb begin
        w_here = 1'b0;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if (i_pending[f] && (FLOOR_W'(f) == i_current_floor)) begin
                w_here = 1'b1;
            end
        end
    end

    // Nearest call strictly above: scan top-down so the lowest match wins
    always_comb begin
        w_up_found = 1'b0;
        w_up_floor = '0;
        for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
            if (i_pending[f] && (FLOOR_W'(f) > i_current_floor)) begin
                w_up_found = 1'b1;
                w_up_floor = FLOOR_W'(f);
            end
        end
    end

    // Nearest call strictly below: scan bottom-up so the highest match wins
    always_comb begin
        w_dn_found = 1'b0;
        w_dn_floor = '0;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if (i_pending[f] && (FLOOR_W'(f) < i_current_floor)) begin
                w_dn_found = 1'b1;
                w_dn_floor = FLOOR_W'(f);
            end
        end
    end

    // Arbitrate: current floor, then sweep direction, then reversed sweep
    always_comb begin
        o_found        = 1'b1;
        o_target       = i_current_floor;
        o_new_sweep_up = i_sweep_up;
        if (w_here) begin
            o_target = i_current_floor;
        end else if (i_sweep_up == DIR_UP) begin
            if (w_up_found) begin
                o_target = w_up_floor;
            end else if (w_dn_found) begin
                o_target       = w_dn_floor;
                o_new_sweep_up = DIR_DOWN;
            end else begin
                o_found = 1'b0;
            end
        end else begin
            if (w_dn_found) begin
                o_target = w_dn_floor;
            end else if (w_up_found) begin
                o_target       = w_up_floor;
                o_new_sweep_up = DIR_UP;
            end else begin
                o_found = 1'b0;
            end
        end
    end

endmodule : scan_select
`default_nettype wire

// File: rtl/elevator_call_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : elevator_call_dispatcher
//  Description : Latches call buttons into a pending bitmap, dispatches one
//                target floor at a time to the elevator core using SCAN,
//                detects arrival and holds a door dwell before the next call.
//  Revision    : 1.0 - initial release
// ============================================================================
module elevator_call_dispatcher
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS   = 10,
    parameter int DWELL_CYCLES = 8
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] i_call_btn,
    input  logic [FLOOR_W-1:0]    i_current_floor,
    input  logic                  i_moving,
    input  logic                  i_direction,
    output logic [FLOOR_W-1:0]    o_request_floor,
    output logic [NUM_FLOORS-1:0] o_pending,
    output logic                  o_door_open,
    output logic                  o_served,
    output logic                  o_sweep_up
);

    localparam int               CNT_W        = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [NUM_FLOORS-1:0]   r_pending;
    logic [NUM_FLOORS-1:0]   w_pending_next;
    logic [NUM_FLOORS-1:0]   w_clear_mask;
    logic [NUM_FLOORS-1:0]   w_cur_mask;
    logic [NUM_FLOORS-1:0]   w_req_mask;
    logic [FLOOR_W-1:0]      r_request_floor;
    logic [FLOOR_W-1:0]      w_req_next;
    logic                    r_sweep_up;
    logic                    w_sweep_next;
    logic                    r_door_open;
    logic                    w_door_next;
    logic                    r_served;
    logic                    w_served_next;
    logic [CNT_W-1:0]        r_dwell_cnt;
    logic [CNT_W-1:0]        w_cnt_next;
    logic                    w_arrival;
    logic                    w_call_here;
    logic                    w_found;
    logic [FLOOR_W-1:0]      w_target;
    logic                    w_new_sweep_up;
    logic                    w_unused_dir;

    // Direction from the core is informational only
    assign w_unused_dir = i_direction;

    scan_select #(
        .NUM_FLOORS     (NUM_FLOORS)
    ) u_scan_select (
        .i_pending      (r_pending),
        .i_current_floor(i_current_floor),
        .i_sweep_up     (r_sweep_up),
        .o_found        (w_found),
        .o_target       (w_target),
        .o_new_sweep_up (w_new_sweep_up)
    );

    // One-hot decode of current and requested floor; out-of-range floors decode to zero
    always_comb begin
        w_cur_mask = '0;
        w_req_mask = '0;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            w_cur_mask[f] = (FLOOR_W'(f) == i_current_floor);
            w_req_mask[f] = (FLOOR_W'(f) == r_request_floor);
        end
    end

    assign w_arrival   = (i_current_floor == r_request_floor) && !i_moving;
    assign w_call_here = |(i_call_btn & w_cur_mask);

    // Calls cleared this cycle: the served floor on arrival, the door floor while dwelling
    always_comb begin
        w_clear_mask = '0;
        if ((r_state == ST_TRAVEL) && w_arrival) begin
            w_clear_mask = w_req_mask;
        end else if (r_state == ST_DWELL) begin
            w_clear_mask = w_cur_mask;
        end
    end

    assign w_pending_next = (r_pending | i_call_btn) & ~w_clear_mask;

    // Next-state and registered-output logic for the dispatch FSM
    always_comb begin
        w_state_next  = r_state;
        w_req_next    = r_request_floor;
        w_sweep_next  = r_sweep_up;
        w_door_next   = r_door_open;
        w_served_next = 1'b0;
        w_cnt_next    = r_dwell_cnt;
        case (r_state)
            ST_IDLE: begin
                w_req_next = i_current_floor;
                if (|w_pending_next) begin
                    w_state_next = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (w_found) begin
                    w_req_next   = w_target;
                    w_sweep_next = w_new_sweep_up;
                    w_state_next = ST_TRAVEL;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_TRAVEL: begin
                if (w_arrival) begin
                    w_served_next = 1'b1;
                    w_door_next   = 1'b1;
                    w_cnt_next    = c_DWELL_LOAD;
                    w_state_next  = ST_DWELL;
                end
            end
            ST_DWELL: begin
                if (w_call_here) begin
                    w_cnt_next = c_DWELL_LOAD;
                end else if (r_dwell_cnt == '0) begin
                    w_door_next  = 1'b0;
                    w_state_next = (|w_pending_next) ? ST_SELECT : ST_IDLE;
                end else begin
                    w_cnt_next = r_dwell_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath registers: pending bitmap, target, sweep, door, served pulse, dwell count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending       <= '0;
            r_request_floor <= '0;
            r_sweep_up      <= DIR_UP;
            r_door_open     <= 1'b0;
            r_served        <= 1'b0;
            r_dwell_cnt     <= '0;
        end else begin
            r_pending       <= w_pending_next;
            r_request_floor <= w_req_next;
            r_sweep_up      <= w_sweep_next;
            r_door_open     <= w_door_next;
            r_served        <= w_served_next;
            r_dwell_cnt     <= w_cnt_next;
        end
    end

    assign o_request_floor = r_request_floor;
    assign o_pending       = r_pending;
    assign o_door_open     = r_door_open;
    assign o_served        = r_served;
    assign o_sweep_up      = r_sweep_up;

endmodule : elevator_call_dispatcher
`default_nettype wire

// File: tb/tb_elevator_call_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : tb_elevator_call_dispatcher
//  Description : Directed bench for elevator_call_dispatcher with a simple
//                car model that moves one floor every four clocks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_elevator_call_dispatcher;

    localparam int NUM_FLOORS   = 10;
    localparam int DWELL_CYCLES = 8;

    logic                  clk;
    logic                  rst_n;
    logic [NUM_FLOORS-1:0] call_btn;
    logic [3:0]            cur;
    logic                  moving;
    logic                  dir;
    logic [3:0]            o_request_floor;
    logic [NUM_FLOORS-1:0] o_pending;
    logic                  o_door_open;
    logic                  o_served;
    logic                  o_sweep_up;

    int total;
    int bad;
    int served_cnt;
    int served_log[$];
    int sweep_log[$];
    int mcnt;
    bit model_on;

    assign dir = (o_request_floor > cur);

    elevator_call_dispatcher #(
        .NUM_FLOORS     (NUM_FLOORS),
        .DWELL_CYCLES   (DWELL_CYCLES)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_call_btn     (call_btn),
        .i_current_floor(cur),
        .i_moving       (moving),
        .i_direction    (dir),
        .o_request_floor(o_request_floor),
        .o_pending      (o_pending),
        .o_door_open    (o_door_open),
        .o_served       (o_served),
        .o_sweep_up     (o_sweep_up)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One clock: sample outputs after the edge, log served calls, advance the car model
    task automatic tick();
        @(posedge clk);
        #1;
        if (o_served) begin
            served_cnt++;
            served_log.push_back(int'(o_request_floor));
            sweep_log.push_back(int'(o_sweep_up));
        end
        if (model_on) begin
            if (cur == o_request_floor) begin
                moving = 1'b0;
                mcnt   = 0;
            end else begin
                moving = 1'b1;
                mcnt++;
                if (mcnt == 4) begin
                    mcnt = 0;
                    if (o_request_floor > cur) cur = cur + 4'd1;
                    else                       cur = cur - 4'd1;
                end
            end
        end
    endtask

    task automatic do_reset(input int floor);
        model_on = 1'b0;
        call_btn = '0;
        moving   = 1'b0;
        mcnt     = 0;
        cur      = 4'(floor);
        rst_n    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        model_on = 1'b1;
    endtask

    task automatic press(input int mask);
        call_btn = NUM_FLOORS'(mask);
        tick();
        call_btn = '0;
    endtask

    task automatic wait_served(input string tag, input int budget);
        int start;
        int n;
        start = served_cnt;
        n     = 0;
        while (served_cnt == start && n < budget) begin
            tick();
            n++;
        end
        check({tag, " served seen"}, int'(served_cnt != start), 1);
    endtask

    task automatic count_door(output int n);
        n = 0;
        while (o_door_open && n < 100) begin
            n++;
            tick();
        end
    endtask

    initial begin
        int n;
        int start;
        int mv;
        int hold_bad;

        total      = 0;
        bad        = 0;
        served_cnt = 0;
        model_on   = 1'b0;
        call_btn   = '0;
        moving     = 1'b0;
        mcnt       = 0;
        cur        = 4'd0;
        rst_n      = 1'b0;

        // ---- Test 1: reset values, single call to floor 5
        tick();
        tick();
        check("rst request_floor", int'(o_request_floor), 0);
        check("rst pending",       int'(o_pending), 0);
        check("rst door_open",     int'(o_door_open), 0);
        check("rst served",        int'(o_served), 0);
        check("rst sweep_up",      int'(o_sweep_up), 1);
        rst_n = 1'b1;
        repeat (3) tick();
        model_on = 1'b1;

        press(32'h020);
        check("t1 pending latched", int'(o_pending), 32'h020);
        check("t1 req after latch", int'(o_request_floor), 0);
        tick();
        check("t1 req after select", int'(o_request_floor), 5);
        start = served_cnt;
        wait_served("t1", 200);
        check("t1 served floor", served_log[$], 5);
        check("t1 pending cleared", int'(o_pending), 0);
        count_door(n);
        check("t1 door cycles", n, 8);
        check("t1 served pulses", served_cnt - start, 1);
        check("t1 idle req holds floor", int'(o_request_floor), 5);

        // ---- Test 2: from floor 0, calls 3 and 7 on the up sweep
        do_reset(0);
        press(32'h088);
        wait_served("t2 first", 300);
        check("t2 first floor", served_log[$], 3);
        check("t2 first sweep", sweep_log[$], 1);
        check("t2 pending after first", int'(o_pending), 32'h080);
        wait_served("t2 second", 300);
        check("t2 second floor", served_log[$], 7);
        check("t2 second sweep", sweep_log[$], 1);

        // ---- Test 3: at floor 4 sweeping up, calls 2 and 8
        do_reset(4);
        press(32'h104);
        wait_served("t3 first", 300);
        check("t3 first floor", served_log[$], 8);
        check("t3 first sweep", sweep_log[$], 1);
        wait_served("t3 second", 300);
        check("t3 second floor", served_log[$], 2);
        check("t3 second sweep", sweep_log[$], 0);

        // ---- Test 4: call at current floor 2, repeat press during dwell
        do_reset(2);
        mv    = 0;
        start = served_cnt;
        press(32'h004);
        n = 1;
        while (served_cnt == start && n < 10) begin
            tick();
            n++;
            if (moving) mv = 1;
        end
        check("t4 served latency", n, 3);
        check("t4 served floor", served_log[$], 2);
        n = 0;
        while (o_door_open && n < 60) begin
            n++;
            if (n == 4) check("t4 press absorbed", int'(o_pending), 0);
            call_btn = (n == 3) ? NUM_FLOORS'(32'h004) : '0;
            tick();
            if (moving) mv = 1;
        end
        call_btn = '0;
        check("t4 door cycles restarted", n, 11);
        check("t4 single served", served_cnt - start, 1);
        check("t4 car never moved", mv, 0);

        // ---- Test 5: call 9 during travel to 6 does not retarget
        do_reset(0);
        press(32'h040);
        tick();
        check("t5 req 6", int'(o_request_floor), 6);
        repeat (8) tick();
        press(32'h200);
        start    = served_cnt;
        hold_bad = 0;
        n        = 0;
        while (served_cnt == start && n < 200) begin
            if (o_request_floor != 4'd6) hold_bad = 1;
            tick();
            n++;
        end
        check("t5 first served seen", int'(served_cnt != start), 1);
        check("t5 req held at 6", hold_bad, 0);
        check("t5 first floor", served_log[$], 6);
        check("t5 pending 9 left", int'(o_pending), 32'h200);
        wait_served("t5 second", 300);
        check("t5 second floor", served_log[$], 9);

        // ---- Test 6: asynchronous reset mid-travel with pending 0x0A4
        do_reset(9);
        press(32'h0A4);
        tick();
        check("t6 req 7", int'(o_request_floor), 7);
        check("t6 sweep flipped down", int'(o_sweep_up), 0);
        check("t6 pending", int'(o_pending), 32'h0A4);
        repeat (5) tick();
        start = served_cnt;
        #2;
        rst_n    = 1'b0;
        model_on = 1'b0;
        #1;
        check("t6 async req",     int'(o_request_floor), 0);
        check("t6 async pending", int'(o_pending), 0);
        check("t6 async door",    int'(o_door_open), 0);
        check("t6 async served",  int'(o_served), 0);
        check("t6 async sweep",   int'(o_sweep_up), 1);
        repeat (3) tick();
        rst_n    = 1'b1;
        moving   = 1'b0;
        mcnt     = 0;
        model_on = 1'b1;
        repeat (40) tick();
        check("t6 no served after release", served_cnt - start, 0);
        check("t6 pending stays empty", int'(o_pending), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_elevator_call_dispatcher
`default_nettype wire
